// File: rtl/wb_commit_if.sv
// Upstream handshake bundle feeding the writeback commit buffer.
interface wb_commit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc_next;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_rd_data;
    logic            in_rd_we;

    modport master (
        output in_valid, in_pc_next, in_rd, in_rd_data, in_rd_we,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc_next, in_rd, in_rd_data, in_rd_we,
        output in_ready
    );
endinterface

// File: rtl/wb_commit.sv
// Writeback commit stage: small in-order buffer that retires one entry per cycle,
// updates the architectural PC, drives the register-file write port and traps on misaligned targets.
module wb_commit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_8000),
    parameter logic [XLEN-1:0] TRAP_PC  = XLEN'(32'h0000_0100),
    parameter int              DEPTH    = 2,
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    wb_commit_if.slave       up,
    input  logic             stall,
    input  logic             flush,
    output logic [XLEN-1:0]  pc,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             trap,
    output logic [XLEN-1:0]  trap_pc,
    output logic [CNT_W-1:0] instret
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc_next;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic            rd_we;
    } entry_t;

    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]  count;
    logic                 live;
    entry_t               head;
    logic                 push, pop, misaligned;

    // in_ready depends only on registered state, never on stall/flush/in_valid.
    assign up.in_ready = live && (count < CNT_BITS'(DEPTH));

    assign push       = up.in_valid && up.in_ready && !flush;
    assign pop        = (count != '0) && !stall && !flush;
    assign head       = mem[rd_ptr];
    assign misaligned = head.pc_next[1:0] != 2'b00;

    // NOTE: the entry storage is deliberately left without reset; count and pointers
    // alone decide which slots are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{up.in_pc_next, up.in_rd, up.in_rd_data, up.in_rd_we};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live     <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pc       <= RESET_PC;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            trap     <= 1'b0;
            trap_pc  <= '0;
            instret  <= '0;
        end else begin
            live  <= 1'b1;
            rf_we <= 1'b0;
            trap  <= 1'b0;
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (pop && misaligned) begin
                // A trapping head squashes everything behind it, including a same-edge push.
                pc      <= TRAP_PC;
                trap_pc <= head.pc_next;
                trap    <= 1'b1;
                count   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    pc       <= head.pc_next;
                    instret  <= instret + CNT_W'(1);
                    rf_we    <= head.rd_we && (head.rd != 5'd0);
                    rf_waddr <= head.rd;
                    rf_wdata <= head.rd_data;
                end
                count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
            end
        end
    end
endmodule

// File: tb/tb_wb_commit.sv
// Randomised bench for wb_commit, checked against a queue-based model of the commit rules.
module tb_wb_commit;
    localparam int              XLEN     = 32;
    localparam int              DEPTH    = 2;
    localparam int              CNT_W    = 4;
    localparam logic [31:0]     RESET_PC = 32'h0000_8000;
    localparam logic [31:0]     TRAP_PC  = 32'h0000_0100;

    typedef struct {
        logic [31:0] pc_next;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        rd_we;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic [31:0]      pc;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             trap;
    logic [31:0]      trap_pc;
    logic [CNT_W-1:0] instret;

    wb_commit_if #(.XLEN(XLEN)) bus ();

    wb_commit #(
        .XLEN(XLEN), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .up(bus), .stall(stall), .flush(flush),
        .pc(pc), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .trap(trap), .trap_pc(trap_pc), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t             q[$];
    logic [31:0]      m_pc;
    logic [CNT_W-1:0] m_instret;
    logic [31:0]      m_trap_pc;
    logic             m_we, m_trap, m_alive;
    logic [4:0]       m_waddr;
    logic [31:0]      m_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #2;
        check("rst_pc", pc, RESET_PC);
        check("rst_rf_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_trap", trap, 0);
        check("rst_trap_pc", trap_pc, 0);
        check("rst_instret", instret, 0);
        check("rst_ready", bus.in_ready, 0);
        q.delete();
        m_pc = RESET_PC; m_instret = '0; m_trap_pc = '0;
        m_we = 1'b0; m_trap = 1'b0; m_alive = 1'b0;
        @(posedge clk); #1;
        check("rst_ready_hold", bus.in_ready, 0);
        rst = 1'b1;
    endtask

    // One clock: drive inputs, predict the edge from the model, compare afterwards.
    task automatic step(input logic v, input logic [31:0] pn, input logic [4:0] rd,
                        input logic [31:0] d, input logic we, input logic st,
                        input logic fl, output logic acc);
        logic rdy;
        ent_t e, h;
        bus.in_valid = v; bus.in_pc_next = pn; bus.in_rd = rd;
        bus.in_rd_data = d; bus.in_rd_we = we; stall = st; flush = fl;
        rdy = m_alive && (q.size() < DEPTH);
        check("in_ready", bus.in_ready, rdy);
        acc = v && rdy && !fl;
        e = '{pn, rd, d, we};
        @(posedge clk); #1;
        m_alive = 1'b1; m_we = 1'b0; m_trap = 1'b0;
        if (fl) begin
            q.delete();
            acc = 1'b0;
        end else if (q.size() > 0 && !st) begin
            h = q.pop_front();
            if (h.pc_next[1:0] != 2'b00) begin
                m_pc = TRAP_PC; m_trap_pc = h.pc_next; m_trap = 1'b1;
                q.delete();
                acc = 1'b0;
            end else begin
                m_pc = h.pc_next;
                m_instret = m_instret + 1'b1;
                m_we = h.rd_we && (h.rd != 0);
                m_waddr = h.rd; m_wdata = h.rd_data;
                if (acc) q.push_back(e);
            end
        end else if (acc) begin
            q.push_back(e);
        end
        check("pc", pc, m_pc);
        check("instret", instret, m_instret);
        check("trap", trap, m_trap);
        check("trap_pc", trap_pc, m_trap_pc);
        check("rf_we", rf_we, m_we);
        if (m_we) begin
            check("rf_waddr", rf_waddr, m_waddr);
            check("rf_wdata", rf_wdata, m_wdata);
        end
    endtask

    task automatic idle(input logic st);
        logic acc;
        step(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, st, 1'b0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        logic acc;
        int   sent;
        bus.in_valid = 1'b0; bus.in_pc_next = '0; bus.in_rd = '0;
        bus.in_rd_data = '0; bus.in_rd_we = 1'b0;
        @(negedge clk);
        apply_reset();

        // Basic writeback after reset release.
        idle(1'b0);
        step(1'b1, 32'h8004, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, acc);
        check("basic_acc", acc, 1);
        idle(1'b0);
        check("basic_we", rf_we, 1);
        check("basic_waddr", rf_waddr, 5);
        check("basic_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("basic_pc", pc, 32'h8004);
        check("basic_instret", instret, 1);
        idle(1'b0);

        // Back-to-back pushes into a stalled buffer, then drain.
        sent = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h8010 + 32'(4 * sent), 5'(sent + 1), 32'h1000 + 32'(sent),
                 1'b1, 1'b1, 1'b0, acc);
            if (acc) sent++;
        end
        check("full_ready", bus.in_ready, 0);
        check("full_sent", sent, 2);
        for (int i = 0; i < 6; i++) begin
            step(sent < 3, 32'h8010 + 32'(4 * sent), 5'(sent + 1), 32'h1000 + 32'(sent),
                 1'b1, 1'b0, 1'b0, acc);
            if (acc) sent++;
        end
        check("drain_sent", sent, 3);

        // x0 write retires without touching the register file.
        step(1'b1, 32'h8008, 5'd0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, acc);
        idle(1'b0);
        check("x0_we", rf_we, 0);
        check("x0_pc", pc, 32'h8008);

        // Misaligned head traps and squashes the entry behind it.
        step(1'b1, 32'h8002, 5'd3, 32'h1, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 32'h800C, 5'd4, 32'h2, 1'b1, 1'b1, 1'b0, acc);
        idle(1'b0);
        check("trap_pulse", trap, 1);
        check("trap_pcval", trap_pc, 32'h8002);
        check("trap_newpc", pc, 32'h0100);
        idle(1'b0);
        check("trap_once", trap, 0);
        check("trap_empty", bus.in_ready, 1);

        // Flush with two buffered entries and a concurrent push.
        step(1'b1, 32'h8020, 5'd6, 32'h6, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 32'h8024, 5'd7, 32'h7, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 32'h8028, 5'd8, 32'h8, 1'b1, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("flush_pc", pc, 32'h0100);

        // Asynchronous reset in the middle of a stream.
        step(1'b1, 32'h8030, 5'd9, 32'h9, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 32'h8034, 5'd10, 32'hA, 1'b1, 1'b1, 1'b0, acc);
        idle(1'b0);
        check("mid_we_before", rf_we, 1);
        apply_reset();
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Randomised traffic; small CNT_W makes instret wrap repeatedly.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pn;
            logic [4:0]  rd;
            pn = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) pn[1:0] = 2'($urandom_range(1, 3));
            rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step($urandom_range(0, 9) < 7, pn, rd, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_commit.md
WB_COMMIT -- requirements
Module: wb_commit

Parameters
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_8000, PC value at reset.
REQ-003 SHALL have parameter TRAP_PC, default 32'h0000_0100, PC loaded on misaligned target.
REQ-004 SHALL have parameter DEPTH, default 2, commit-buffer entries (power of two, >=2).
REQ-005 SHALL have parameter CNT_W, default 64, retired-instruction counter width.

Interface
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  buffer can accept an entry.
REQ-010 in_pc_next  in  XLEN  PC after this instruction.
REQ-011 in_rd  in  5  destination register index.
REQ-012 in_rd_data  in  XLEN  result data.
REQ-013 in_rd_we  in  1  instruction writes rd.
REQ-014 stall  in  1  downstream blocks commit this cycle.
REQ-015 flush  in  1  discard all buffered entries.
REQ-016 pc  out  XLEN  architectural PC.
REQ-017 rf_we / rf_waddr / rf_wdata  out  1/5/XLEN  register-file write port, registered.
REQ-018 trap  out  1  one-cycle pulse on misaligned target.
REQ-019 trap_pc  out  XLEN  faulting in_pc_next, held until next trap.
REQ-020 instret  out  CNT_W  retired-instruction count.

Function
REQ-021 Entry (pc_next, rd, rd_data, rd_we) SHALL be pushed on an edge where in_valid && in_ready && !flush.
REQ-022 in_ready SHALL equal (count < DEPTH), derived from registered count only; no combinational path from stall, flush or in_valid.
REQ-023 Head entry SHALL commit on an edge where count > 0 && !stall && !flush; earliest commit is the edge after the push (latency 1).
REQ-024 Push and commit on the same edge SHALL leave count unchanged; count range 0..DEPTH, pointers wrap modulo DEPTH.
REQ-025 Commit with pc_next[1:0] == 2'b00 SHALL load pc <= pc_next, increment instret, and drive rf_we = rd_we && (rd != 0), rf_waddr = rd, rf_wdata = rd_data for exactly the following cycle.
REQ-026 Writes to x0 SHALL never assert rf_we, but still retire and update pc.
REQ-027 Commit with pc_next[1:0] != 2'b00 SHALL load pc <= TRAP_PC, trap_pc <= pc_next, pulse trap one cycle, suppress rf_we, leave instret unchanged, and discard all other buffered entries (count <= 0).
REQ-028 flush SHALL set count and pointers to 0 on that edge, override push and commit, and leave pc, instret, trap_pc unchanged.
REQ-029 rf_we and trap SHALL be 0 in every cycle not immediately following a qualifying commit.
REQ-030 instret SHALL wrap from 2^CNT_W-1 to 0.
REQ-031 Empty buffer (count == 0) SHALL produce no commit regardless of stall.

Reset
REQ-032 rst low SHALL immediately force pc = RESET_PC, count = 0, in_ready = 0 while low, rf_we = 0, rf_waddr = 0, rf_wdata = 0, trap = 0, trap_pc = 0, instret = 0.
REQ-033 in_ready SHALL rise to 1 on the first edge after rst deasserts; reset mid-operation SHALL discard buffered entries with no commit.

Verification
REQ-034 Reset release, push {pc_next=0x8004, rd=5, data=0xDEAD_BEEF, we=1} -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, pc=0x8004, instret=1.
REQ-035 stall=1, push 3 entries back-to-back (DEPTH=2) -> in_ready=0 after 2nd push, 3rd held; release stall -> 3 commits in order, one per cycle.
REQ-036 Push rd=0, we=1, pc_next=0x8008 -> rf_we stays 0, pc=0x8008, instret increments.
REQ-037 Buffer holding {0x8002, 0x800C} -> trap pulse, pc=0x0100, trap_pc=0x8002, count=0, rf_we=0, instret unchanged.
REQ-038 flush with 2 entries buffered and simultaneous in_valid -> count=0, no rf_we, pc unchanged, pushed entry discarded.
REQ-039 rst asserted mid-stream with stall=0 -> pc=0x8000 and rf_we=0 asynchronously, no commit after release until a new push.
